// File: rtl/softmax_seq.sv
// Row phase sequencer for the STAR softmax datapath: fetch, max search,
// subtract, exponent lookup, and saturating accumulation of exp values.
module softmax_seq #(
    parameter int N_ELEM  = 16,
    parameter int N_ROW   = 16,
    parameter int ADDR_W  = 9,
    parameter int EXP_W   = 32,
    parameter int EXP_LAT = 2,
    localparam int EW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1,
    localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              data_req,
    output logic [ADDR_W-1:0] data_addr,
    output logic              CAMSUB_req,
    output logic              FindSub_req,
    output logic              EXP_req,
    input  logic [EXP_W-1:0]  exp,
    output logic [EXP_W-1:0]  Sum_exp,
    output logic              sum_sat,
    output logic [EW-1:0]     elem_idx,
    output logic [RW-1:0]     row_idx,
    output logic              row_done,
    output logic              busy,
    output logic              finish
);

    localparam int CW = $clog2(N_ELEM + EXP_LAT + 1);
    localparam logic [CW-1:0] C_NE  = CW'(N_ELEM);
    localparam logic [CW-1:0] C_NE1 = CW'(N_ELEM - 1);
    localparam logic [CW-1:0] C_DR  = CW'(EXP_LAT - 1);
    localparam logic [RW-1:0] C_LROW = RW'(N_ROW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SUB, S_EXP, S_DRAIN, S_ROWEND, S_DONE
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [RW-1:0]       r_row;
    logic [EXP_LAT-1:0]  r_tap;
    logic                r_data_req;
    logic [ADDR_W-1:0]   r_data_addr;
    logic                r_camsub;
    logic                r_findsub;
    logic                r_exp_req;
    logic [EXP_W-1:0]    r_sum;
    logic                r_sat;
    logic [EW-1:0]       r_elem;
    logic                r_row_done;
    logic                r_busy;
    logic                r_finish;

    state_t              w_nstate;
    logic [CW-1:0]       w_ncnt;
    logic [RW-1:0]       w_nrow;
    logic [EW-1:0]       w_elem;
    logic                w_ld_req;
    logic                w_load_entry;
    logic [EXP_W:0]      w_sum;

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nrow   = r_row;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_nstate = S_LOAD;
                    w_ncnt   = '0;
                    w_nrow   = '0;
                end
            end
            S_LOAD: begin
                if (r_cnt == C_NE) begin
                    w_nstate = S_SUB;
                    w_ncnt   = '0;
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
            S_SUB: begin
                if (r_cnt == C_NE1) begin
                    w_nstate = S_EXP;
                    w_ncnt   = '0;
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
            S_EXP: begin
                if (r_cnt == C_NE1) begin
                    w_nstate = S_DRAIN;
                    w_ncnt   = '0;
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_cnt == C_DR) begin
                    w_nstate = S_ROWEND;
                    w_ncnt   = '0;
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
            S_ROWEND: begin
                w_ncnt = '0;
                if (r_row == C_LROW) begin
                    w_nstate = S_DONE;
                end else begin
                    w_nstate = S_LOAD;
                    w_nrow   = r_row + 1'b1;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        w_elem = '0;
        unique case (w_nstate)
            S_LOAD:       w_elem = (w_ncnt != '0) ? EW'(w_ncnt - 1'b1) : '0;
            S_SUB, S_EXP: w_elem = EW'(w_ncnt);
            default:      w_elem = '0;
        endcase
    end

    assign w_ld_req     = (w_nstate == S_LOAD) && (w_ncnt < C_NE);
    assign w_load_entry = (w_nstate == S_LOAD) && (r_state != S_LOAD);
    assign w_sum        = {1'b0, r_sum} + {1'b0, exp};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_tap       <= '0;
            r_data_req  <= 1'b0;
            r_data_addr <= '0;
            r_camsub    <= 1'b0;
            r_findsub   <= 1'b0;
            r_exp_req   <= 1'b0;
            r_sum       <= '0;
            r_sat       <= 1'b0;
            r_elem      <= '0;
            r_row_done  <= 1'b0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            r_row    <= w_nrow;
            r_tap[0] <= r_exp_req;
            for (int i = 1; i < EXP_LAT; i++) begin
                r_tap[i] <= r_tap[i-1];
            end
            r_data_req  <= w_ld_req;
            r_data_addr <= w_ld_req ? ADDR_W'(w_nrow * N_ELEM + w_ncnt) : '0;
            r_camsub    <= (w_nstate == S_LOAD) && (w_ncnt != '0);
            r_findsub   <= (w_nstate == S_SUB);
            r_exp_req   <= (w_nstate == S_EXP);
            r_elem      <= w_elem;
            r_row_done  <= (w_nstate == S_ROWEND);
            r_busy      <= (w_nstate != S_IDLE) && (w_nstate != S_DONE);
            r_finish    <= (w_nstate == S_DONE);
            if (w_load_entry) begin
                r_sum <= '0;
                r_sat <= 1'b0;
            end else if (r_tap[EXP_LAT-1]) begin
                if (w_sum[EXP_W]) begin
                    r_sum <= '1;
                    r_sat <= 1'b1;
                end else begin
                    r_sum <= w_sum[EXP_W-1:0];
                end
            end
        end
    end

    assign data_req    = r_data_req;
    assign data_addr   = r_data_addr;
    assign CAMSUB_req  = r_camsub;
    assign FindSub_req = r_findsub;
    assign EXP_req     = r_exp_req;
    assign Sum_exp     = r_sum;
    assign sum_sat     = r_sat;
    assign elem_idx    = r_elem;
    assign row_idx     = r_row;
    assign row_done    = r_row_done;
    assign busy        = r_busy;
    assign finish      = r_finish;

endmodule

// File: tb/tb_softmax_seq.sv
// Scoreboard bench for softmax_seq: expected fetches, row sums and finish
// times are queued at job start and popped by an independent monitor.
module tb_softmax_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] exp_in = '0;
    logic        data_req, CAMSUB_req, FindSub_req, EXP_req;
    logic [8:0]  data_addr;
    logic [31:0] Sum_exp;
    logic        sum_sat, row_done, busy, finish;
    logic [3:0]  elem_idx, row_idx;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          row;
        logic [31:0] sum;
        logic        sat;
    } row_t;

    typedef struct {
        logic v;
        int   r;
        int   k;
    } h_t;

    int   q_addr[$];
    row_t q_row[$];
    int   q_fin[$];

    softmax_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .data_req(data_req), .data_addr(data_addr),
        .CAMSUB_req(CAMSUB_req), .FindSub_req(FindSub_req),
        .EXP_req(EXP_req), .exp(exp_in), .Sum_exp(Sum_exp),
        .sum_sat(sum_sat), .elem_idx(elem_idx), .row_idx(row_idx),
        .row_done(row_done), .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] outs();
        return {data_req, data_addr, CAMSUB_req, FindSub_req, EXP_req,
                Sum_exp, sum_sat, elem_idx, row_idx, row_done, busy, finish};
    endfunction

    // Row pattern: rows 4m+2 saturate, 4m+1 get exp=1, others get k+1.
    function automatic logic [31:0] exp_val(input int r, input int k);
        case (r % 4)
            2:       return 32'h4000_0000;
            1:       return 32'd1;
            default: return 32'(k + 1);
        endcase
    endfunction

    task automatic push_job(input int c0);
        row_t e;
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 16; k++) q_addr.push_back(r * 16 + k);
            e.row = r;
            case (r % 4)
                2:       begin e.sum = 32'hFFFF_FFFF; e.sat = 1'b1; end
                1:       begin e.sum = 32'd16;        e.sat = 1'b0; end
                default: begin e.sum = 32'd136;       e.sat = 1'b0; end
            endcase
            q_row.push_back(e);
        end
        q_fin.push_back(c0 + 833);
    endtask

    task automatic issue_start();
        push_job(cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = finish;
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    // LUT model: exp is valid EXP_LAT=2 cycles after the EXP_req cycle.
    initial begin
        h_t h0, h1, h2;
        h0 = '{1'b0, 0, 0};
        h1 = h0;
        h2 = h0;
        forever begin
            @(negedge clk);
            h2 = h1;
            h1 = h0;
            h0 = '{EXP_req, int'(row_idx), int'(elem_idx)};
            exp_in = h2.v ? exp_val(h2.r, h2.k) : 32'h0000_0100;
        end
    end

    initial begin
        logic       prev_dreq = 1'b0;
        logic [8:0] prev_addr = '0;
        logic       prev_fin = 1'b0;
        int n_d = 0, n_c = 0, n_f = 0, n_e = 0, nreq;
        row_t e;
        forever begin
            @(negedge clk);
            if (data_req) begin
                if (q_addr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL fetch: unexpected addr %0d", data_addr);
                end else begin
                    chk("data_addr", 64'(data_addr), 64'(q_addr.pop_front()));
                end
                chk("load_sum_clear", {sum_sat, Sum_exp}, 64'd0);
            end
            if (CAMSUB_req || prev_dreq)
                chk("camsub_lag", 64'(CAMSUB_req), 64'(prev_dreq));
            if (CAMSUB_req)
                chk("camsub_elem", 64'(elem_idx), 64'(prev_addr[3:0]));
            if (busy) begin
                nreq = int'(data_req | CAMSUB_req) + int'(FindSub_req)
                     + int'(EXP_req) + int'(row_done);
                chk("req_exclusive", 64'(nreq <= 1), 64'd1);
            end
            n_d += int'(data_req);
            n_c += int'(CAMSUB_req);
            n_f += int'(FindSub_req);
            n_e += int'(EXP_req);
            if (row_done) begin
                if (q_row.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL row_done: unexpected for row %0d", row_idx);
                end else begin
                    e = q_row.pop_front();
                    chk("row_idx", 64'(row_idx), 64'(e.row));
                    chk("Sum_exp", 64'(Sum_exp), 64'(e.sum));
                    chk("sum_sat", 64'(sum_sat), 64'(e.sat));
                    chk("phase_counts", {8'(n_d), 8'(n_c), 8'(n_f), 8'(n_e)},
                        64'h1010_1010);
                end
                n_d = 0; n_c = 0; n_f = 0; n_e = 0;
            end
            if (finish && !prev_fin) begin
                if (q_fin.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL finish: unexpected at cycle %0d", cyc);
                end else begin
                    chk("finish_cycle", 64'(cyc), 64'(q_fin.pop_front()));
                    chk("rows_left", 64'(q_row.size()), 64'd0);
                    chk("busy_in_done", 64'(busy), 64'd0);
                end
            end
            if (!busy) begin
                n_d = 0; n_c = 0; n_f = 0; n_e = 0;
            end
            prev_dreq = data_req;
            prev_addr = data_addr;
            prev_fin  = finish;
        end
    end

    initial begin
        bit seen;
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", outs(), 64'd0);
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle", outs(), 64'd0);
        end

        issue_start();
        wait_finish("jobA_finish_seen");
        repeat (3) @(negedge clk);
        chk("done_hold", {finish, busy, Sum_exp}, {2'b10, 32'd136});

        issue_start();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = FindSub_req;
        end
        chk("jobB_sub_seen", 64'(seen), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = FindSub_req && (row_idx == 4'd5);
        end
        chk("jobB_row5_seen", 64'(seen), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_finish("jobB_finish_seen");

        issue_start();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = EXP_req && (elem_idx == 4'd7);
        end
        chk("jobC_exp7_seen", 64'(seen), 64'd1);
        chk("partial_sum", 64'(Sum_exp), 64'd15);
        reset = 1'b1;
        start = 1'b1;
        q_addr.delete();
        q_row.delete();
        q_fin.delete();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("reset_mid_exp", outs(), 64'd0);
        repeat (60) @(negedge clk);
        chk("idle_after_reset", {busy, finish, Sum_exp}, 64'd0);

        issue_start();
        wait_finish("jobD_finish_seen");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
